// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory controller frontend.
// The arbiter connects through the slave modport; the requesters/memory side uses master.
interface mem_arbiter_if;
  logic        m0_req;
  logic        m0_write;
  logic [15:0] m0_addr;
  logic [15:0] m0_data_w;
  logic [15:0] m0_data_r;
  logic        m0_ack;

  logic        m1_req;
  logic        m1_write;
  logic [15:0] m1_addr;
  logic [15:0] m1_data_w;
  logic [15:0] m1_data_r;
  logic        m1_ack;

  logic        mem_enable;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_w;
  logic [15:0] mem_data_r;

  logic [1:0]  grant;
  logic        busy;

  modport slave (
    input  m0_req, m0_write, m0_addr, m0_data_w,
    input  m1_req, m1_write, m1_addr, m1_data_w,
    input  mem_data_r,
    output m0_data_r, m0_ack, m1_data_r, m1_ack,
    output mem_enable, mem_write, mem_addr, mem_data_w,
    output grant, busy
  );

  modport master (
    output m0_req, m0_write, m0_addr, m0_data_w,
    output m1_req, m1_write, m1_addr, m1_data_w,
    output mem_data_r,
    input  m0_data_r, m0_ack, m1_data_r, m1_ack,
    input  mem_enable, mem_write, mem_addr, mem_data_w,
    input  grant, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and fixed-length access sequencer in front of the memory frontend.
// Define MEM_ARB_FIXED_PRIO_EN to make port 1 win every tie instead of alternating.
module mem_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic        owner;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [15:0] data_w_q;
  logic [15:0] data_r0;
  logic [15:0] data_r1;
  logic        any_req;
  logic        win;
  logic        start;

  assign any_req = bus.m0_req | bus.m1_req;
  assign start   = (state == IDLE) && any_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign win = bus.m1_req;
`else
  logic last;

  // On a tie the port that did not win most recently goes next; a lone request always wins.
  assign win = (bus.m0_req && bus.m1_req) ? ~last : bus.m1_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (start) begin
      last <= win;
    end
  end
`endif

  // NOTE: always_ff blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // NOTE: state_n gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 4'd0;
      owner    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 16'h0000;
      data_w_q <= 16'h0000;
      data_r0  <= 16'h0000;
      data_r1  <= 16'h0000;
    end else begin
      if (start) begin
        owner    <= win;
        wr_q     <= win ? bus.m1_write  : bus.m0_write;
        addr_q   <= win ? bus.m1_addr   : bus.m0_addr;
        data_w_q <= win ? bus.m1_data_w : bus.m0_data_w;
        cnt      <= CNT_LOAD;
      end else if (state == ACCESS) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (!wr_q) begin
          if (owner) data_r1 <= bus.mem_data_r;
          else       data_r0 <= bus.mem_data_r;
        end
      end
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them immediately.
  assign bus.mem_enable = (state == ACCESS);
  assign bus.mem_write  = (state == ACCESS) && wr_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_data_w = data_w_q;

  assign bus.m0_ack     = (state == DONE) && !owner;
  assign bus.m1_ack     = (state == DONE) &&  owner;
  assign bus.m0_data_r  = data_r0;
  assign bus.m1_data_r  = data_r1;

  assign bus.grant      = (state == IDLE) ? 2'b00 : {owner, ~owner};
  assign bus.busy       = (state != IDLE);

endmodule
